// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART transmitter and the future receiver.
// Optional even parity is selected by the UART_TX_PARITY_EN macro (see uart_tx.sv).
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

    // Clock cycles per bit, rounded to nearest.
    function automatic int unsigned baud_divisor(input int unsigned clk_freq,
                                                 input int unsigned baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: valid/ready byte handshake between the CPU UART register and the transmitter.
interface uart_tx_if
    import uart_pkg::*;
    ();

    logic [UART_DATA_BITS-1:0] tx_data;
    logic                      tx_valid;
    logic                      tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/uart_baud_counter.sv
// uart_baud_counter: free-running 0..DIVISOR-1 bit-period counter with synchronous clear.
// bit_done is high in the last cycle of each bit period.
module uart_baud_counter #(
    parameter int unsigned DIVISOR = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic bit_done
);

    localparam int unsigned CW = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

    logic [CW-1:0] count;

    // Count bit-period cycles; wrap at the end of each bit, restart on clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign bit_done = (count == LAST);

endmodule

// File: rtl/uart_tx.sv
// uart_tx: byte-serial UART transmitter, 8N1 by default.
// Define UART_TX_PARITY_EN to add an even parity bit (8E1 frame).
// Transmission is gated by the 2-flop-synchronised PLL lock signal.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 100_500_000,
    parameter int unsigned BAUD     = 115_200,
    parameter int unsigned DIVISOR  = baud_divisor(CLK_FREQ, BAUD)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          locked,
    uart_tx_if.slave      bus,
    output logic          tx,
    output logic          busy
);

    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

    uart_tx_state_t            state;
    logic [1:0]                lock_sync;
    logic                      lock_s;
    logic [UART_DATA_BITS-1:0] shreg;
    logic [2:0]                bit_cnt;
    logic                      accept;
    logic                      clear;
    logic                      bit_done;
`ifdef UART_TX_PARITY_EN
    logic                      parity_bit;
`endif

    // Two-flop synchroniser for the PLL lock input.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_sync <= '0;
        end else begin
            lock_sync <= {lock_sync[0], locked};
        end
    end

    assign lock_s       = lock_sync[1];
    assign bus.tx_ready = (state == IDLE) && lock_s;
    assign accept       = bus.tx_valid && bus.tx_ready;

    // Every non-abort state change happens on bit_done, where the counter wraps
    // to 0 by itself; holding clear in IDLE and on lock loss covers the other entries.
    assign clear = (state == IDLE) || !lock_s;

    uart_baud_counter #(
        .DIVISOR (DIVISOR)
    ) u_baud (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (clear),
        .bit_done (bit_done)
    );

    // Frame sequencer with registered line and busy outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            tx         <= 1'b1;
            busy       <= 1'b0;
            shreg      <= '0;
            bit_cnt    <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else if (state != IDLE && !lock_s) begin
            state   <= IDLE;
            tx      <= 1'b1;
            busy    <= 1'b0;
            bit_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg      <= bus.tx_data;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= ^bus.tx_data;
`endif
                        bit_cnt    <= '0;
                        tx         <= 1'b0;
                        busy       <= 1'b1;
                        state      <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        tx    <= shreg[0];
                        shreg <= shreg >> 1;
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                            tx      <= parity_bit;
                            state   <= PARITY;
`else
                            tx      <= 1'b1;
                            state   <= STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_done) begin
                        tx    <= 1'b1;
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (bit_done) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
